// File: rtl/apb_burst_pkg.sv
// apb_burst_pkg: shared state encoding, error codes and default error word for the APB burst master
package apb_burst_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_WR, S_SETUP, S_ACCESS, S_RD_HOLD, S_ERROR} state_e;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SLV  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_SEL  = 2'd3;
  localparam logic [15:0] ERR_WORD_DEFAULT = 16'h4552;
endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: counts ACCESS cycles and flags the last one allowed before abandoning the transfer
module apb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q;
  // the count equals the number of ACCESS cycles already spent, so TIMEOUT-1 marks the final one
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 1'b1;
  assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/apb_burst_master_fsm.sv
// apb_burst_master_fsm: turns SPI command headers and data words into single/burst APB transfers
module apb_burst_master_fsm
  import apb_burst_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int N_SLV = 2,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_WORD_DEFAULT),
  localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic              cmd_burst,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic              cs_abort,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr,
  output logic [N_SLV-1:0]  psel,
  output logic              penable,
  output logic              pwrite,
  output logic [STRB_W-1:0] pstrb,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(STRB_W);
  state_e state_q, state_d;
  logic write_q, write_d, burst_q, burst_d, abort_q, abort_d, abort_any, bad_sel, tmo_expired;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d, paddr_q, paddr_d;
  logic [N_SLV-1:0] psel_q, psel_d;
  logic penable_q, penable_d, pwrite_q, pwrite_d, rdata_valid_q, rdata_valid_d, err_q, err_d, busy_q, busy_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [1:0] err_code_q, err_code_d;

  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk),
    .reset_n(reset_n),
    .clr(state_q == S_SETUP),
    .en(state_q == S_ACCESS),
    .expired(tmo_expired)
  );

  assign bad_sel = {1'b0, cmd_sel} >= (SEL_W + 1)'(N_SLV);

  // next-state and next-output logic; a chip-select abort in ACCESS is only remembered, never acted on mid-transfer
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    burst_d = burst_q;
    sel_d = sel_q;
    addr_d = addr_q;
    abort_any = abort_q | cs_abort;
    abort_d = (state_q == S_IDLE) ? 1'b0 : abort_any;
    psel_d = psel_q;
    penable_d = penable_q;
    pwrite_d = pwrite_q;
    pstrb_d = pstrb_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d = rdata_q;
    rdata_valid_d = 1'b0;
    err_d = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        psel_d = '0;
        penable_d = 1'b0;
        rdata_d = '0;
        if (cmd_valid) begin
          write_d = cmd_write;
          burst_d = cmd_burst;
          sel_d = cmd_sel;
          addr_d = cmd_addr;
          err_code_d = bad_sel ? ERR_SEL : ERR_NONE;
          err_d = bad_sel;
          rdata_d = bad_sel ? ERR_WORD : '0;
          state_d = bad_sel ? S_ERROR : (cmd_write ? S_WAIT_WR : S_SETUP);
        end
      end
      S_WAIT_WR: begin
        if (cs_abort) state_d = S_IDLE;
        else if (wr_valid) begin
          pwdata_d = wr_data;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready || tmo_expired) begin
          psel_d = '0;
          penable_d = 1'b0;
          addr_d = addr_q + INC;
          if (!pready || pslverr) begin
            err_d = 1'b1;
            err_code_d = pready ? ERR_SLV : ERR_TMO;
            rdata_d = ERR_WORD;
            state_d = S_ERROR;
          end else if (write_q) state_d = (burst_q && !abort_any) ? S_WAIT_WR : S_IDLE;
          else begin
            rdata_d = prdata;
            rdata_valid_d = 1'b1;
            state_d = abort_any ? S_IDLE : S_RD_HOLD;
          end
        end
      end
      S_RD_HOLD: begin
        if (cs_abort) state_d = S_IDLE;
        else if (rd_req) state_d = burst_q ? S_SETUP : S_IDLE;
      end
      S_ERROR: begin
        if (cs_abort || abort_q) state_d = S_IDLE;
        else if (burst_q && err_code_q != ERR_SEL) begin
          if (write_q ? wr_valid : rd_req) begin
            pwdata_d = write_q ? wr_data : pwdata_q;
            state_d = S_SETUP;
          end
        end else if (wr_valid || rd_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_SETUP) begin
      psel_d = N_SLV'(1) << sel_d;
      penable_d = 1'b0;
      pwrite_d = write_d;
      pstrb_d = '1;
      paddr_d = addr_d;
    end
    busy_d = state_d != S_IDLE;
  end

  // every output is registered; reset clears them all immediately
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      burst_q <= 1'b0;
      sel_q <= '0;
      addr_q <= '0;
      abort_q <= 1'b0;
      psel_q <= '0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      pstrb_q <= '0;
      paddr_q <= '0;
      pwdata_q <= '0;
      rdata_q <= '0;
      rdata_valid_q <= 1'b0;
      err_q <= 1'b0;
      err_code_q <= ERR_NONE;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      burst_q <= burst_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      abort_q <= abort_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      pstrb_q <= pstrb_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q <= err_d;
      err_code_q <= err_code_d;
      busy_q <= busy_d;
    end

  assign psel = psel_q;
  assign penable = penable_q;
  assign pwrite = pwrite_q;
  assign pstrb = pstrb_q;
  assign paddr = paddr_q;
  assign pwdata = pwdata_q;
  assign rdata = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign err = err_q;
  assign err_code = err_code_q;
  assign busy = busy_q;
endmodule
